// File: rtl/neuron_spike_aer_tx.sv
// AER output transmitter: queues post-neuron spike vectors and time-step markers,
// then serializes one address per spike over a 4-phase REQ/ACK handshake.
module neuron_spike_aer_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ACK_SYNC   = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] NEUR_EVENT_OUT,
    input  logic [9:0] CTRL_POST_NEURON_ADDRESS,
    input  logic       CTRL_POST_NEUR_CS,
    input  logic       CTRL_POST_NEUR_WE,
    input  logic       CTRL_TSTEP_EVENT,
    input  logic       SPI_GATE_ACTIVITY_sync,
    input  logic       CLR_OVF,
    output logic [7:0] AEROUT_ADDR,
    output logic       AEROUT_TSTEP,
    output logic       AEROUT_REQ,
    input  logic       AEROUT_ACK,
    output logic       FIFO_EMPTY,
    output logic       FIFO_FULL,
    output logic       OVERFLOW,
    output logic [7:0] DROP_CNT
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT_LOW} state_t;

    logic        cap;
    logic        tstep_in;
    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic        pop;
    logic [10:0] push_data;
    logic [10:0] head;
    logic        empty;
    logic        full;
    logic        ack_s;
    logic [1:0]  lsb_idx;

    logic          tstep_pend_q, tstep_pend_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [10:0]   mem_q [FIFO_DEPTH];
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    state_t        state_q, state_d;
    logic          mk_q, mk_d;
    logic [5:0]    base_q, base_d;
    logic [3:0]    vec_q, vec_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    addr_q, addr_d;
    logic          tstep_q, tstep_d;
    logic          req_q, req_d;

    // ---------------- capture and FIFO ----------------
    assign cap      = CTRL_POST_NEUR_CS & CTRL_POST_NEUR_WE & (|NEUR_EVENT_OUT)
                      & ~SPI_GATE_ACTIVITY_sync;
    assign tstep_in = CTRL_TSTEP_EVENT & ~SPI_GATE_ACTIVITY_sync;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_req  = cap | tstep_pend_q;
        push_data = cap ? {1'b0, CTRL_POST_NEURON_ADDRESS[7:2], NEUR_EVENT_OUT}
                        : {1'b1, 6'd0, 4'b0001};
        // A same-edge pop frees the slot, so a full FIFO still accepts the push.
        push_ok   = push_req & (~full | pop);
        drop      = push_req & full & ~pop;

        // The marker leaves the pending state whether it was stored or dropped;
        // a step arriving on that edge merges into it.
        if (tstep_pend_q && !cap) tstep_pend_d = 1'b0;
        else                      tstep_pend_d = tstep_pend_q | tstep_in;

        wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = CLR_OVF ? 8'd1
                       : (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
        end else if (CLR_OVF) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    // ---------------- acknowledge synchronizer ----------------
    generate
        if (ACK_SYNC != 0) begin : g_ack_sync
            logic [1:0] ack_sync_q;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) ack_sync_q <= '0;
                else        ack_sync_q <= {ack_sync_q[0], AEROUT_ACK};
            end
            assign ack_s = ack_sync_q[1];
        end else begin : g_ack_direct
            assign ack_s = AEROUT_ACK;
        end
    endgenerate

    // ---------------- serializer ----------------
    always_comb begin
        lsb_idx = 2'd0;
        if      (vec_q[0]) lsb_idx = 2'd0;
        else if (vec_q[1]) lsb_idx = 2'd1;
        else if (vec_q[2]) lsb_idx = 2'd2;
        else if (vec_q[3]) lsb_idx = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        mk_d    = mk_q;
        base_d  = base_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        tstep_d = tstep_q;
        req_d   = req_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop                   = 1'b1;
                    {mk_d, base_d, vec_d} = head;
                    state_d               = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d   = lsb_idx;
                addr_d  = mk_q ? 8'd0 : {base_q, lsb_idx};
                tstep_d = mk_q;
                req_d   = 1'b1;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    vec_d   = vec_q & ~(4'b0001 << idx_q);
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!ack_s) state_d = (vec_q != '0) ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tstep_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            drop_cnt_q   <= '0;
            state_q      <= S_IDLE;
            mk_q         <= 1'b0;
            base_q       <= '0;
            vec_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            tstep_q      <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            tstep_pend_q <= tstep_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
            mk_q         <= mk_d;
            base_q       <= base_d;
            vec_q        <= vec_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            tstep_q      <= tstep_d;
            req_q        <= req_d;
        end
    end

    assign AEROUT_ADDR  = addr_q;
    assign AEROUT_TSTEP = tstep_q;
    assign AEROUT_REQ   = req_q;
    assign FIFO_EMPTY   = empty;
    assign FIFO_FULL    = full;
    assign OVERFLOW     = ovf_q;
    assign DROP_CNT     = drop_cnt_q;

endmodule

// File: tb/tb_neuron_spike_aer_tx.sv
// Directed self-checking bench for neuron_spike_aer_tx (FIFO_DEPTH=16, ACK_SYNC=1).
module tb_neuron_spike_aer_tx;

    logic       CLK;
    logic       RST_N;
    logic [3:0] NEUR_EVENT_OUT;
    logic [9:0] CTRL_POST_NEURON_ADDRESS;
    logic       CTRL_POST_NEUR_CS;
    logic       CTRL_POST_NEUR_WE;
    logic       CTRL_TSTEP_EVENT;
    logic       SPI_GATE_ACTIVITY_sync;
    logic       CLR_OVF;
    logic [7:0] AEROUT_ADDR;
    logic       AEROUT_TSTEP;
    logic       AEROUT_REQ;
    logic       AEROUT_ACK;
    logic       FIFO_EMPTY;
    logic       FIFO_FULL;
    logic       OVERFLOW;
    logic [7:0] DROP_CNT;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    neuron_spike_aer_tx #(
        .FIFO_DEPTH(16),
        .ACK_SYNC  (1)
    ) dut (
        .CLK                     (CLK),
        .RST_N                   (RST_N),
        .NEUR_EVENT_OUT          (NEUR_EVENT_OUT),
        .CTRL_POST_NEURON_ADDRESS(CTRL_POST_NEURON_ADDRESS),
        .CTRL_POST_NEUR_CS       (CTRL_POST_NEUR_CS),
        .CTRL_POST_NEUR_WE       (CTRL_POST_NEUR_WE),
        .CTRL_TSTEP_EVENT        (CTRL_TSTEP_EVENT),
        .SPI_GATE_ACTIVITY_sync  (SPI_GATE_ACTIVITY_sync),
        .CLR_OVF                 (CLR_OVF),
        .AEROUT_ADDR             (AEROUT_ADDR),
        .AEROUT_TSTEP            (AEROUT_TSTEP),
        .AEROUT_REQ              (AEROUT_REQ),
        .AEROUT_ACK              (AEROUT_ACK),
        .FIFO_EMPTY              (FIFO_EMPTY),
        .FIFO_FULL               (FIFO_FULL),
        .OVERFLOW                (OVERFLOW),
        .DROP_CNT                (DROP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_capture(input logic [9:0] addr, input logic [3:0] ev);
        CTRL_POST_NEURON_ADDRESS = addr;
        NEUR_EVENT_OUT           = ev;
        CTRL_POST_NEUR_CS        = 1'b1;
        CTRL_POST_NEUR_WE        = 1'b1;
    endtask

    task automatic clear_inputs();
        CTRL_POST_NEURON_ADDRESS = '0;
        NEUR_EVENT_OUT           = '0;
        CTRL_POST_NEUR_CS        = 1'b0;
        CTRL_POST_NEUR_WE        = 1'b0;
        CTRL_TSTEP_EVENT         = 1'b0;
        CLR_OVF                  = 1'b0;
    endtask

    // Bounded 4-phase responder for one event with its expected address/marker.
    task automatic handshake(input string tag, input logic [7:0] a, input logic t);
        int unsigned n;
        n = 0;
        while (!AEROUT_REQ && n < 60) begin tick(); n++; end
        check({tag, "_req_rise"}, 32'(AEROUT_REQ), 32'd1);
        check({tag, "_addr"}, 32'(AEROUT_ADDR), 32'(a));
        check({tag, "_tstep"}, 32'(AEROUT_TSTEP), 32'(t));
        AEROUT_ACK = 1'b1;
        n = 0;
        while (AEROUT_REQ && n < 60) begin tick(); n++; end
        check({tag, "_req_fall"}, 32'(AEROUT_REQ), 32'd0);
        AEROUT_ACK = 1'b0;
        tick();
        check({tag, "_req_gap"}, 32'(AEROUT_REQ), 32'd0);
    endtask

    initial begin
        RST_N                  = 1'b0;
        AEROUT_ACK             = 1'b0;
        SPI_GATE_ACTIVITY_sync = 1'b0;
        clear_inputs();
        #1;
        check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
        check("rst_full", 32'(FIFO_FULL), 32'd0);
        check("rst_req", 32'(AEROUT_REQ), 32'd0);
        check("rst_addr", 32'(AEROUT_ADDR), 32'd0);
        check("rst_tstep", 32'(AEROUT_TSTEP), 32'd0);
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        check("rst_drop", 32'(DROP_CNT), 32'd0);
        #11;
        RST_N = 1'b1;
        tick();
        tick();

        // 1: single capture and latency
        set_capture(10'h014, 4'b0100);
        tick();
        check("t1_entry_present", 32'(FIFO_EMPTY), 32'd0);
        check("t1_req_e0", 32'(AEROUT_REQ), 32'd0);
        clear_inputs();
        tick();
        check("t1_req_e1", 32'(AEROUT_REQ), 32'd0);
        tick();
        check("t1_req_e2", 32'(AEROUT_REQ), 32'd1);
        handshake("t1", 8'h16, 1'b0);
        check("t1_empty_after", 32'(FIFO_EMPTY), 32'd1);
        repeat (8) tick();
        check("t1_idle_req", 32'(AEROUT_REQ), 32'd0);

        // 2: multi-lane entry, ascending lanes, ADDR[9:8] ignored
        set_capture(10'h3FC, 4'b1011);
        tick();
        clear_inputs();
        handshake("t2_l0", 8'hFC, 1'b0);
        handshake("t2_l1", 8'hFD, 1'b0);
        handshake("t2_l3", 8'hFF, 1'b0);
        repeat (8) tick();
        check("t2_no_extra", 32'(AEROUT_REQ), 32'd0);

        // 3: spike and time step on the same cycle
        set_capture(10'h008, 4'b0001);
        CTRL_TSTEP_EVENT = 1'b1;
        tick();
        clear_inputs();
        handshake("t3_spike", 8'h08, 1'b0);
        handshake("t3_marker", 8'h00, 1'b1);
        repeat (8) tick();
        check("t3_no_extra", 32'(AEROUT_REQ), 32'd0);

        // 4: overflow with one event stuck in REQ, then ordered drain
        set_capture({2'b00, 6'h30, 2'b00}, 4'b0001);
        tick();
        clear_inputs();
        tick();
        tick();
        check("t4_blocker_req", 32'(AEROUT_REQ), 32'd1);
        for (int i = 0; i < 19; i++) begin
            set_capture({2'b00, 6'(i), 2'b00}, 4'b0001);
            tick();
        end
        clear_inputs();
        check("t4_full", 32'(FIFO_FULL), 32'd1);
        check("t4_ovf", 32'(OVERFLOW), 32'd1);
        check("t4_drop", 32'(DROP_CNT), 32'd3);
        handshake("t4_blocker", 8'hC0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            handshake($sformatf("t4_drain%0d", i), 8'(i * 4), 1'b0);
        end
        repeat (8) tick();
        check("t4_empty", 32'(FIFO_EMPTY), 32'd1);
        check("t4_no_extra", 32'(AEROUT_REQ), 32'd0);
        check("t4_ovf_sticky", 32'(OVERFLOW), 32'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("t4_clr_ovf", 32'(OVERFLOW), 32'd0);
        check("t4_clr_drop", 32'(DROP_CNT), 32'd0);

        // 5: gated activity produces nothing
        SPI_GATE_ACTIVITY_sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_capture(10'h0F0, 4'b1111);
            CTRL_TSTEP_EVENT = i[0];
            tick();
            check("t5_gate_empty", 32'(FIFO_EMPTY), 32'd1);
        end
        clear_inputs();
        tick();
        SPI_GATE_ACTIVITY_sync = 1'b0;
        repeat (10) tick();
        check("t5_empty", 32'(FIFO_EMPTY), 32'd1);
        check("t5_req", 32'(AEROUT_REQ), 32'd0);
        check("t5_drop", 32'(DROP_CNT), 32'd0);

        // 6: reset during a handshake with 5 entries queued
        for (int i = 0; i < 6; i++) begin
            set_capture({2'b00, 6'(i + 8), 2'b00}, 4'b0001);
            tick();
        end
        clear_inputs();
        check("t6_req_up", 32'(AEROUT_REQ), 32'd1);
        check("t6_queued", 32'(FIFO_EMPTY), 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        check("t6_rst_req", 32'(AEROUT_REQ), 32'd0);
        check("t6_rst_empty", 32'(FIFO_EMPTY), 32'd1);
        repeat (2) tick();
        #3;
        RST_N = 1'b1;
        repeat (20) tick();
        check("t6_post_req", 32'(AEROUT_REQ), 32'd0);
        check("t6_post_empty", 32'(FIFO_EMPTY), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
